// File: rtl/idex_forward_stage.sv
// ID/EX pipeline register with registered forward codes, one-bubble load-use stall,
// flush and hold. Optional IDEX_WB_BYPASS_EN: write-back bypass onto captured operands.
module idexOperandLane #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rfData,
  input  logic              idexValid,
  input  logic              idexRegWrite,
  input  logic [REG_W-1:0]  idexDst,
  input  logic              exmemRegWrite,
  input  logic [REG_W-1:0]  exmemDst,
  input  logic              memwbRegWrite,
  input  logic [REG_W-1:0]  memwbDst,
  input  logic [DATA_W-1:0] memwbData,
  output logic [1:0]        fwdCode,
  output logic [DATA_W-1:0] opData
);
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  logic srcLive;
  assign srcLive = (src != '0);

  // Today's ID/EX lands in EX/MEM and today's EX/MEM in MEM/WB by the time
  // this operand reaches EX, so the youngest producer is checked first.
  always_comb begin
    fwdCode = FWD_NONE;
    if (srcLive && idexValid && idexRegWrite && idexDst == src)
      fwdCode = FWD_EXMEM;
    else if (srcLive && exmemRegWrite && exmemDst == src)
      fwdCode = FWD_MEMWB;
  end

`ifdef IDEX_WB_BYPASS_EN
  assign opData = (srcLive && memwbRegWrite && memwbDst == src) ? memwbData : rfData;
`else
  logic unusedWb;
  assign unusedWb = ^{memwbRegWrite, memwbDst, memwbData};
  assign opData   = rfData;
`endif
endmodule

module idex_forward_stage #(
  parameter int CTRL_W = 16,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idValid,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [REG_W-1:0]  idDst,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic [DATA_W-1:0] idRsData,
  input  logic [DATA_W-1:0] idRtData,
  input  logic [CTRL_W-1:0] idCtrl,
  input  logic              exmemRegWrite,
  input  logic [REG_W-1:0]  exmemDst,
  input  logic              memwbRegWrite,
  input  logic [REG_W-1:0]  memwbDst,
  input  logic [DATA_W-1:0] memwbData,
  input  logic              flush,
  input  logic              hold,
  output logic              stallId,
  output logic              idexValid,
  output logic [REG_W-1:0]  idexRs,
  output logic [REG_W-1:0]  idexRt,
  output logic [REG_W-1:0]  idexDst,
  output logic              idexRegWrite,
  output logic              idexMemRead,
  output logic [DATA_W-1:0] idexRsData,
  output logic [DATA_W-1:0] idexRtData,
  output logic [CTRL_W-1:0] idexCtrl,
  output logic [1:0]        fwdCodeRs,
  output logic [1:0]        fwdCodeRt
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic              regWrite;
    logic              memRead;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        fwdRs;
    logic [1:0]        fwdRt;
  } idexT;

  typedef enum logic {RUN, STALL} stateT;

  idexT  idex, idexNext;
  stateT state;

  logic [NUM_SRC-1:0][REG_W-1:0]  srcReg;
  logic [NUM_SRC-1:0][DATA_W-1:0] rfData;
  logic [NUM_SRC-1:0][DATA_W-1:0] opData;
  logic [NUM_SRC-1:0][1:0]        fwdCode;

  assign srcReg = {idRt, idRs};
  assign rfData = {idRtData, idRsData};

  for (genvar g = 0; g < NUM_SRC; g++) begin : gLane
    idexOperandLane #(.REG_W(REG_W), .DATA_W(DATA_W)) uLane (
      .src          (srcReg[g]),
      .rfData       (rfData[g]),
      .idexValid    (idex.valid),
      .idexRegWrite (idex.regWrite),
      .idexDst      (idex.dst),
      .exmemRegWrite(exmemRegWrite),
      .exmemDst     (exmemDst),
      .memwbRegWrite(memwbRegWrite),
      .memwbDst     (memwbDst),
      .memwbData    (memwbData),
      .fwdCode      (fwdCode[g]),
      .opData       (opData[g])
    );
  end

  logic loadUse;
  assign loadUse = idValid && idex.valid && idex.memRead && (idex.dst != '0) &&
                   (idex.dst == idRs || idex.dst == idRt);

  // In STALL the ID/EX slot holds the bubble, so loadUse cannot re-fire there.
  assign stallId = hold || (state == RUN && loadUse && !flush);

  always_comb begin
    idexNext = '0;
    if (idValid) begin
      idexNext.valid    = 1'b1;
      idexNext.rs       = idRs;
      idexNext.rt       = idRt;
      idexNext.dst      = idDst;
      idexNext.regWrite = idRegWrite;
      idexNext.memRead  = idMemRead;
      idexNext.rsData   = opData[0];
      idexNext.rtData   = opData[1];
      idexNext.ctrl     = idCtrl;
      idexNext.fwdRs    = fwdCode[0];
      idexNext.fwdRt    = fwdCode[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex  <= '0;
      state <= RUN;
    end else if (hold) begin
      idex  <= idex;
      state <= state;
    end else if (flush) begin
      idex  <= '0;
      state <= RUN;
    end else if (state == RUN && loadUse) begin
      idex  <= '0;
      state <= STALL;
    end else begin
      idex  <= idexNext;
      state <= RUN;
    end
  end

  assign idexValid    = idex.valid;
  assign idexRs       = idex.rs;
  assign idexRt       = idex.rt;
  assign idexDst      = idex.dst;
  assign idexRegWrite = idex.regWrite;
  assign idexMemRead  = idex.memRead;
  assign idexRsData   = idex.rsData;
  assign idexRtData   = idex.rtData;
  assign idexCtrl     = idex.ctrl;
  assign fwdCodeRs    = idex.fwdRs;
  assign fwdCodeRt    = idex.fwdRt;
endmodule

// File: tb/tb_idex_forward_stage.sv
// Directed bench for idex_forward_stage: forwarding codes, load-use bubble, flush, hold, reset.
module tb_idex_forward_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idValid = 1'b0;
  logic [4:0]  idRs = '0, idRt = '0, idDst = '0;
  logic        idRegWrite = 1'b0, idMemRead = 1'b0;
  logic [31:0] idRsData = '0, idRtData = '0;
  logic [15:0] idCtrl = '0;
  logic        exmemRegWrite = 1'b0;
  logic [4:0]  exmemDst = '0;
  logic        memwbRegWrite = 1'b0;
  logic [4:0]  memwbDst = '0;
  logic [31:0] memwbData = '0;
  logic        flush = 1'b0, hold = 1'b0;
  logic        stallId, idexValid, idexRegWrite, idexMemRead;
  logic [4:0]  idexRs, idexRt, idexDst;
  logic [31:0] idexRsData, idexRtData;
  logic [15:0] idexCtrl;
  logic [1:0]  fwdCodeRs, fwdCodeRt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idex_forward_stage dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt), .idDst(idDst),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idRsData(idRsData), .idRtData(idRtData),
    .idCtrl(idCtrl), .exmemRegWrite(exmemRegWrite), .exmemDst(exmemDst),
    .memwbRegWrite(memwbRegWrite), .memwbDst(memwbDst), .memwbData(memwbData),
    .flush(flush), .hold(hold), .stallId(stallId), .idexValid(idexValid), .idexRs(idexRs),
    .idexRt(idexRt), .idexDst(idexDst), .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead),
    .idexRsData(idexRsData), .idexRtData(idexRtData), .idexCtrl(idexCtrl),
    .fwdCodeRs(fwdCodeRs), .fwdCodeRt(fwdCodeRt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] c);
    idValid = v; idRs = rs; idRt = rt; idDst = dst; idRegWrite = rw; idMemRead = mr;
    idRsData = a; idRtData = b; idCtrl = c;
  endtask

  task automatic clearId;
    setId(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    exmemRegWrite = 1'b0; exmemDst = '0;
    memwbRegWrite = 1'b0; memwbDst = '0; memwbData = '0;
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 16'hABCD);
    step; step;
    checks++; if (idexValid !== 1'b0) begin errors++; $display("FAIL reset valid got=%b exp=0", idexValid); end
    checks++; if (idexRs !== 5'd0) begin errors++; $display("FAIL reset rs got=%0d exp=0", idexRs); end
    checks++; if (idexRegWrite !== 1'b0 || idexMemRead !== 1'b0) begin errors++; $display("FAIL reset rw/mr got=%b%b exp=00", idexRegWrite, idexMemRead); end
    checks++; if (idexRsData !== 32'h0 || idexRtData !== 32'h0) begin errors++; $display("FAIL reset data got=%h/%h exp=0", idexRsData, idexRtData); end
    checks++; if (idexCtrl !== 16'h0) begin errors++; $display("FAIL reset ctrl got=%h exp=0", idexCtrl); end
    checks++; if (fwdCodeRs !== 2'b00 || fwdCodeRt !== 2'b00) begin errors++; $display("FAIL reset codes got=%b/%b exp=00/00", fwdCodeRs, fwdCodeRt); end
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL reset stall got=%b exp=0", stallId); end
    rst = 1'b0;
    clearId;
    step;
  endtask

  task automatic test_back_to_back;
    setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h100, 32'h200, 16'h0011);
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL b2b stall0 got=%b exp=0", stallId); end
    step;
    setId(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 32'h300, 32'h500, 16'h0022);
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL b2b stall1 got=%b exp=0", stallId); end
    step;
    checks++; if (fwdCodeRs !== 2'b01) begin errors++; $display("FAIL b2b fwdRs got=%b exp=01", fwdCodeRs); end
    checks++; if (fwdCodeRt !== 2'b00) begin errors++; $display("FAIL b2b fwdRt got=%b exp=00", fwdCodeRt); end
    checks++; if (idexValid !== 1'b1 || idexRs !== 5'd3 || idexRt !== 5'd5 || idexDst !== 5'd4) begin
      errors++; $display("FAIL b2b regs got=%b %0d %0d %0d exp=1 3 5 4", idexValid, idexRs, idexRt, idexDst); end
    checks++; if (idexRsData !== 32'h300 || idexRtData !== 32'h500 || idexCtrl !== 16'h0022) begin
      errors++; $display("FAIL b2b data got=%h %h %h exp=300 500 0022", idexRsData, idexRtData, idexCtrl); end
    clearId;
    step;
  endtask

  task automatic test_distance_two;
    setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2, 16'h0);
    step;
    clearId;
    step;
    exmemRegWrite = 1'b1; exmemDst = 5'd3;
    setId(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 32'h33, 32'h33, 16'h0005);
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL dist2 stall got=%b exp=0", stallId); end
    step;
    checks++; if (fwdCodeRs !== 2'b10 || fwdCodeRt !== 2'b10) begin
      errors++; $display("FAIL dist2 codes got=%b/%b exp=10/10", fwdCodeRs, fwdCodeRt); end
    clearId;
    step;
  endtask

  task automatic test_load_use;
    setId(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'h40, 32'h0, 16'h0101);
    step;
    checks++; if (idexMemRead !== 1'b1) begin errors++; $display("FAIL lu lwMemRead got=%b exp=1", idexMemRead); end
    setId(1'b1, 5'd2, 5'd1, 5'd7, 1'b1, 1'b0, 32'h777, 32'h111, 16'h0202);
    #1;
    checks++; if (stallId !== 1'b1) begin errors++; $display("FAIL lu stall got=%b exp=1", stallId); end
    step;
    checks++; if (idexValid !== 1'b0 || idexRegWrite !== 1'b0 || idexCtrl !== 16'h0 || fwdCodeRs !== 2'b00) begin
      errors++; $display("FAIL lu bubble got=%b %b %h %b exp=0 0 0000 00", idexValid, idexRegWrite, idexCtrl, fwdCodeRs); end
    exmemRegWrite = 1'b1; exmemDst = 5'd2;
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL lu stallOnce got=%b exp=0", stallId); end
    step;
    checks++; if (idexValid !== 1'b1 || idexRs !== 5'd2 || idexDst !== 5'd7) begin
      errors++; $display("FAIL lu reissue got=%b %0d %0d exp=1 2 7", idexValid, idexRs, idexDst); end
    checks++; if (fwdCodeRs !== 2'b10 || fwdCodeRt !== 2'b00) begin
      errors++; $display("FAIL lu codes got=%b/%b exp=10/00", fwdCodeRs, fwdCodeRt); end
    clearId;
    step;
  endtask

  task automatic test_flush_load_use;
    setId(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'h40, 32'h0, 16'h0101);
    step;
    setId(1'b1, 5'd2, 5'd1, 5'd7, 1'b1, 1'b0, 32'h777, 32'h111, 16'h0202);
    flush = 1'b1;
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL flush stall got=%b exp=0", stallId); end
    step;
    flush = 1'b0;
    checks++; if (idexValid !== 1'b0 || idexRegWrite !== 1'b0 || idexMemRead !== 1'b0) begin
      errors++; $display("FAIL flush bubble got=%b %b %b exp=0 0 0", idexValid, idexRegWrite, idexMemRead); end
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL flush noSecondStall got=%b exp=0", stallId); end
    step;
    checks++; if (idexValid !== 1'b1 || idexRs !== 5'd2 || fwdCodeRs !== 2'b00) begin
      errors++; $display("FAIL flush resume got=%b %0d %b exp=1 2 00", idexValid, idexRs, fwdCodeRs); end
    clearId;
    step;
  endtask

  task automatic test_hold;
    setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2, 16'h0);
    step;
    setId(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 32'h3333, 32'h5555, 16'h0044);
    step;
    setId(1'b1, 5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 32'h4444, 32'h4444, 16'h0088);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stallId !== 1'b1) begin errors++; $display("FAIL hold%0d stall got=%b exp=1", i, stallId); end
      step;
      checks++; if (idexValid !== 1'b1 || idexRs !== 5'd3 || idexDst !== 5'd4 || idexRsData !== 32'h3333 ||
                    idexCtrl !== 16'h0044 || fwdCodeRs !== 2'b01 || fwdCodeRt !== 2'b00) begin
        errors++; $display("FAIL hold%0d frozen got=%b %0d %0d %h %h %b %b exp=1 3 4 00003333 0044 01 00",
                           i, idexValid, idexRs, idexDst, idexRsData, idexCtrl, fwdCodeRs, fwdCodeRt); end
    end
    hold = 1'b0;
    #1;
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL hold release stall got=%b exp=0", stallId); end
    step;
    checks++; if (idexRs !== 5'd4 || idexDst !== 5'd8 || fwdCodeRs !== 2'b01 || fwdCodeRt !== 2'b01) begin
      errors++; $display("FAIL hold resume got=%0d %0d %b %b exp=4 8 01 01", idexRs, idexDst, fwdCodeRs, fwdCodeRt); end
    clearId;
    step;
  endtask

  task automatic test_r0;
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'h1, 32'h2, 16'h0);
    exmemRegWrite = 1'b1; exmemDst = 5'd0;
    step;
    setId(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0);
    step;
    checks++; if (fwdCodeRs !== 2'b00 || fwdCodeRt !== 2'b00) begin
      errors++; $display("FAIL r0 codes got=%b/%b exp=00/00", fwdCodeRs, fwdCodeRt); end
    clearId;
    step;
  endtask

  task automatic test_reset_in_stall;
    setId(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'h40, 32'h0, 16'h0101);
    step;
    setId(1'b1, 5'd2, 5'd1, 5'd7, 1'b1, 1'b0, 32'h777, 32'h111, 16'h0202);
    step;
    rst = 1'b1;
    step;
    checks++; if (idexValid !== 1'b0 || idexRs !== 5'd0 || idexDst !== 5'd0 || idexRsData !== 32'h0 ||
                  idexCtrl !== 16'h0 || fwdCodeRs !== 2'b00) begin
      errors++; $display("FAIL rstStall outputs got=%b %0d %0d %h %h %b exp=all 0",
                         idexValid, idexRs, idexDst, idexRsData, idexCtrl, fwdCodeRs); end
    checks++; if (stallId !== 1'b0) begin errors++; $display("FAIL rstStall stall got=%b exp=0", stallId); end
    rst = 1'b0;
    step;
    checks++; if (idexValid !== 1'b1 || idexRs !== 5'd2 || idexRsData !== 32'h777) begin
      errors++; $display("FAIL rstStall resume got=%b %0d %h exp=1 2 00000777", idexValid, idexRs, idexRsData); end
    clearId;
    step;
  endtask

  task automatic test_bypass;
    logic [31:0] expRs;
`ifdef IDEX_WB_BYPASS_EN
    expRs = 32'hDEADBEEF;
`else
    expRs = 32'h1234;
`endif
    memwbRegWrite = 1'b1; memwbDst = 5'd9; memwbData = 32'hDEADBEEF;
    setId(1'b1, 5'd9, 5'd4, 5'd10, 1'b1, 1'b0, 32'h1234, 32'h5678, 16'h0);
    step;
    checks++; if (idexRsData !== expRs) begin errors++; $display("FAIL bypass rsData got=%h exp=%h", idexRsData, expRs); end
    checks++; if (idexRtData !== 32'h5678) begin errors++; $display("FAIL bypass rtData got=%h exp=00005678", idexRtData); end
    clearId;
    step;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_distance_two;
    test_load_use;
    test_flush_load_use;
    test_hold;
    test_r0;
    test_reset_in_stall;
    test_bypass;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
